// File: rtl/sprite_plot_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_plot_scheduler
//
// Purpose:
//   Shares the single pixel-write port of the 160x120 VGA adapter between
//   NUM_SPRITES moving sprites. Requesters are granted round-robin. For the
//   granted sprite the SIZE x SIZE box at its last drawn position is erased in
//   BG_COLOUR, the box is then drawn at the new position in the sprite colour,
//   and the sprite is acked. One pixel is emitted per enabled cycle.
//
// Ports:
//   clock       in   1       system clock
//   reset_n     in   1       asynchronous, active-low reset
//   enable      in   1       1 = run, 0 = freeze all state (vga_plot forced 0)
//   req         in   N       per-sprite draw request, held until matching ack
//   req_x       in   8*N     sprite i top-left x at [8i+7:8i]
//   req_y       in   8*N     sprite i top-left y at [8i+7:8i]
//   req_colour  in   3*N     sprite i colour at [3i+2:3i]
//   ack         out  N       one-cycle pulse when sprite i is fully redrawn
//   busy        out  1       high whenever the scheduler is not idle
//   vga_x       out  8       pixel x to adapter
//   vga_y       out  8       pixel y to adapter
//   vga_colour  out  3       pixel colour to adapter
//   vga_plot    out  1       pixel write strobe
//
// Configuration:
//   PLOT_CLIP_EN  when defined, pixels with x>=160 or y>=120 are not strobed
//                 (the cycle is still spent, so latency is unchanged). When
//                 undefined every erase/draw pixel is strobed; addresses simply
//                 wrap modulo 256.
// -----------------------------------------------------------------------------
module sprite_plot_scheduler #(
  parameter int         NUM_SPRITES = 3,
  parameter int         SIZE        = 4,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_SPRITES-1:0]     req,
  input  logic [8*NUM_SPRITES-1:0]   req_x,
  input  logic [8*NUM_SPRITES-1:0]   req_y,
  input  logic [3*NUM_SPRITES-1:0]   req_colour,
  output logic [NUM_SPRITES-1:0]     ack,
  output logic                       busy,
  output logic [7:0]                 vga_x,
  output logic [7:0]                 vga_y,
  output logic [2:0]                 vga_colour,
  output logic                       vga_plot
);

  localparam int         PW   = $clog2(NUM_SPRITES);
  localparam logic [2:0] LAST = 3'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [PW-1:0]          rrPtr_q, rrPtr_d;
  logic [2:0]             px_q, px_d, py_q, py_d;
  logic [7:0]             curX_q, curX_d, curY_q, curY_d;
  logic [2:0]             curColour_q, curColour_d;
  logic [7:0]             prevX_q [NUM_SPRITES];
  logic [7:0]             prevX_d [NUM_SPRITES];
  logic [7:0]             prevY_q [NUM_SPRITES];
  logic [7:0]             prevY_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] prevValid_q, prevValid_d;
  logic [7:0]             lastX_q, lastX_d, lastY_q, lastY_d;
  logic [2:0]             lastColour_q, lastColour_d;

  logic [7:0]             reqXArr [NUM_SPRITES];
  logic [7:0]             reqYArr [NUM_SPRITES];
  logic [2:0]             reqCArr [NUM_SPRITES];
  logic                   reqFound;
  logic [PW-1:0]          grantIdx;
  logic [7:0]             pixX, pixY;
  logic [2:0]             pixColour;
  logic                   onScreen;
  logic                   lastPixel;

  // Unpack the flat request buses into per-sprite arrays so the granted
  // sprite's fields can be picked with a plain array index.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      reqXArr[i] = req_x[8*i +: 8];
      reqYArr[i] = req_y[8*i +: 8];
      reqCArr[i] = req_colour[3*i +: 3];
    end
  end

  // Round-robin search: scan from rrPtr upward (mod N). The scan runs from the
  // farthest offset down to offset 0 so the nearest requester wins last.
  always_comb begin
    int idx;
    idx      = 0;
    reqFound = 1'b0;
    grantIdx = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_SPRITES) idx = idx - NUM_SPRITES;
      if (req[PW'(idx)]) begin
        reqFound = 1'b1;
        grantIdx = PW'(idx);
      end
    end
  end

  // Current pixel address: erase walks the previous box in background colour,
  // draw walks the latched new box. Arithmetic wraps modulo 256.
  always_comb begin
    pixX      = curX_q + {5'b00000, px_q};
    pixY      = curY_q + {5'b00000, py_q};
    pixColour = curColour_q;
    if (state_q == ERASE) begin
      pixX      = prevX_q[grant_q] + {5'b00000, px_q};
      pixY      = prevY_q[grant_q] + {5'b00000, py_q};
      pixColour = BG_COLOUR;
    end
  end

`ifdef PLOT_CLIP_EN
  assign onScreen = (pixX < 8'd160) && (pixY < 8'd120);
`else
  assign onScreen = 1'b1;
`endif

  assign lastPixel = (px_q == LAST) && (py_q == LAST);

  // Next-state and output decode. Everything holds when enable is low; in
  // IDLE/DONE the pixel outputs replay the last emitted pixel.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rrPtr_d      = rrPtr_q;
    px_d         = px_q;
    py_d         = py_q;
    curX_d       = curX_q;
    curY_d       = curY_q;
    curColour_d  = curColour_q;
    prevX_d      = prevX_q;
    prevY_d      = prevY_q;
    prevValid_d  = prevValid_q;
    lastX_d      = lastX_q;
    lastY_d      = lastY_q;
    lastColour_d = lastColour_q;
    ack          = '0;
    busy         = (state_q != IDLE);
    vga_x        = lastX_q;
    vga_y        = lastY_q;
    vga_colour   = lastColour_q;
    vga_plot     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && reqFound) begin
          grant_d     = grantIdx;
          curX_d      = reqXArr[grantIdx];
          curY_d      = reqYArr[grantIdx];
          curColour_d = reqCArr[grantIdx];
          px_d        = '0;
          py_d        = '0;
          state_d     = prevValid_q[grantIdx] ? ERASE : DRAW;
        end
      end

      ERASE, DRAW: begin
        vga_x      = pixX;
        vga_y      = pixY;
        vga_colour = pixColour;
        vga_plot   = enable && onScreen;
        if (enable) begin
          lastX_d      = pixX;
          lastY_d      = pixY;
          lastColour_d = pixColour;
          if (px_q == LAST) begin
            px_d = '0;
            py_d = (py_q == LAST) ? 3'd0 : py_q + 3'd1;
          end else begin
            px_d = px_q + 3'd1;
          end
          if (lastPixel) state_d = (state_q == ERASE) ? DRAW : DONE;
        end
      end

      DONE: begin
        if (enable) begin
          ack[grant_q]         = 1'b1;
          prevX_d[grant_q]     = curX_q;
          prevY_d[grant_q]     = curY_q;
          prevValid_d[grant_q] = 1'b1;
          rrPtr_d              = (grant_q == PW'(NUM_SPRITES - 1)) ? '0 : grant_q + 1'b1;
          state_d              = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers: grant, raster counters, latched request, per-sprite
  // history and the last emitted pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= '0;
      rrPtr_q      <= '0;
      px_q         <= '0;
      py_q         <= '0;
      curX_q       <= '0;
      curY_q       <= '0;
      curColour_q  <= '0;
      prevValid_q  <= '0;
      lastX_q      <= '0;
      lastY_q      <= '0;
      lastColour_q <= BG_COLOUR;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        prevX_q[i] <= '0;
        prevY_q[i] <= '0;
      end
    end else begin
      grant_q      <= grant_d;
      rrPtr_q      <= rrPtr_d;
      px_q         <= px_d;
      py_q         <= py_d;
      curX_q       <= curX_d;
      curY_q       <= curY_d;
      curColour_q  <= curColour_d;
      prevValid_q  <= prevValid_d;
      lastX_q      <= lastX_d;
      lastY_q      <= lastY_d;
      lastColour_q <= lastColour_d;
      prevX_q      <= prevX_d;
      prevY_q      <= prevY_d;
    end
  end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sprite_plot_scheduler
//
// Purpose:
//   Self-checking bench for sprite_plot_scheduler (default build, NUM_SPRITES=3,
//   SIZE=4, BG_COLOUR=000). A behavioural model keeps per-sprite history and
//   the round-robin pointer and expands each service into the list of pixels
//   it must produce; observed plots and acks are compared against it.
// -----------------------------------------------------------------------------
module tb_sprite_plot_scheduler;

  localparam int         N  = 3;
  localparam int         S  = 4;
  localparam logic [2:0] BG = 3'b000;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_x;
  logic [8*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   ack;
  logic           busy;
  logic [7:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  int errors = 0;
  int checks = 0;

  bit         mValid [N];
  logic [7:0] mPx [N];
  logic [7:0] mPy [N];
  int         mRr;
  logic [7:0] sx [N];
  logic [7:0] sy [N];
  logic [2:0] sc [N];

  logic [18:0] expPlotQ[$];
  logic [18:0] plotQ[$];
  int          expAckQ[$];
  int          ackIdxQ[$];
  int          ackCycQ[$];
  int          busyLowBetween;

  sprite_plot_scheduler #(.NUM_SPRITES(N), .SIZE(S), .BG_COLOUR(BG)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .ack        (ack),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  // Model reset: forget all sprite history and restart round-robin at 0.
  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 1'b0;
      mPx[i]    = '0;
      mPy[i]    = '0;
    end
    mRr = 0;
  endtask

  // One service of sprite g: optional erase box, draw box, then ack.
  task automatic modelServe(input int g);
    if (mValid[g]) begin
      for (int y = 0; y < S; y++)
        for (int x = 0; x < S; x++)
          expPlotQ.push_back({8'(mPx[g] + 8'(x)), 8'(mPy[g] + 8'(y)), BG});
    end
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++)
        expPlotQ.push_back({8'(sx[g] + 8'(x)), 8'(sy[g] + 8'(y)), sc[g]});
    expAckQ.push_back(g);
    mPx[g]    = sx[g];
    mPy[g]    = sy[g];
    mValid[g] = 1'b1;
    mRr       = (g + 1) % N;
  endtask

  // Serve n requests from a pending mask in round-robin order; held requests
  // stay pending after service.
  task automatic modelRun(input logic [N-1:0] mask, input int n, input bit held);
    for (int s = 0; s < n; s++) begin
      int g;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mask[(mRr + k) % N]) g = (mRr + k) % N;
      if (g < 0) break;
      modelServe(g);
      if (!held) mask[g] = 1'b0;
    end
  endtask

  task automatic setSprite(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic [2:0] c);
    sx[i] = x;
    sy[i] = y;
    sc[i] = c;
    req_x[8*i +: 8]      = x;
    req_y[8*i +: 8]      = y;
    req_colour[3*i +: 3] = c;
  endtask

  task automatic clearQueues();
    expPlotQ.delete();
    plotQ.delete();
    expAckQ.delete();
    ackIdxQ.delete();
    ackCycQ.delete();
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    req     = '0;
    enable  = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    modelReset();
  endtask

  // Steps the clock, recording plots, acks and idle gaps until target acks
  // are seen or the cycle budget runs out. Cycle 1 is the cycle after the
  // grant edge. enable is dropped for offLen cycles starting after cycle
  // offStart.
  task automatic applyStimulus(input int target, input bit dropOnAck, input int offStart,
                               input int offLen, input bit scramble);
    int cyc, budget, seen;
    bit firstAck;
    cyc            = 0;
    seen           = 0;
    firstAck       = 1'b0;
    busyLowBetween = 0;
    budget         = target * (2*S*S + 2) + offLen + 20;
    while (seen < target && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (vga_plot) plotQ.push_back({vga_x, vga_y, vga_colour});
      if (firstAck && !busy) busyLowBetween++;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          ackIdxQ.push_back(i);
          ackCycQ.push_back(cyc);
          seen++;
          firstAck = 1'b1;
          if (dropOnAck) req[i] = 1'b0;
        end
      end
      if (seen >= target) req = '0;
      if (scramble && cyc == 2) begin
        req_x      = 24'($urandom);
        req_y      = 24'($urandom);
        req_colour = 9'($urandom);
      end
      enable = !(cyc >= offStart && cyc < offStart + offLen);
    end
    enable = 1'b1;
    if (seen < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got %0d acks, required %0d", seen, target);
      req = '0;
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b1;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    #2;
    checks += 6;
    if (ack !== '0)       begin errors++; $display("[TB] FAIL rst_ack: got %b expected 000", ack); end
    if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL rst_plot: got %b expected 0", vga_plot); end
    if (vga_x !== 8'd0)   begin errors++; $display("[TB] FAIL rst_x: got %0d expected 0", vga_x); end
    if (vga_y !== 8'd0)   begin errors++; $display("[TB] FAIL rst_y: got %0d expected 0", vga_y); end
    if (vga_colour !== BG) begin errors++; $display("[TB] FAIL rst_colour: got %b expected %b", vga_colour, BG); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    modelReset();
  endtask

  task automatic test_first_draw();
    logic [18:0] lastPix;
    int got;
    @(negedge clock);
    clearQueues();
    setSprite(0, 8'd40, 8'd60, 3'b100);
    modelRun(3'b001, 1, 1'b0);
    req = 3'b001;
    applyStimulus(1, 1'b1, 0, 0, 1'b1);
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t1_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t1_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
    got = ackCycQ.size() > 0 ? ackCycQ[0] : -1;
    checks++;
    if (got != S*S + 1) begin errors++; $display("[TB] FAIL t1_ack_latency: got %0d expected %0d", got, S*S + 1); end
    lastPix = expPlotQ[$];
    @(negedge clock);
    checks += 3;
    if (busy !== 1'b0 || vga_plot !== 1'b0) begin
      errors++; $display("[TB] FAIL t1_idle: got busy=%b plot=%b expected 0/0", busy, vga_plot);
    end
    if ({vga_x, vga_y} !== lastPix[18:3]) begin
      errors++; $display("[TB] FAIL t1_hold_xy: got %h expected %h", {vga_x, vga_y}, lastPix[18:3]);
    end
    if (vga_colour !== lastPix[2:0]) begin
      errors++; $display("[TB] FAIL t1_hold_colour: got %b expected %b", vga_colour, lastPix[2:0]);
    end
  endtask

  task automatic test_redraw();
    int got;
    @(negedge clock);
    clearQueues();
    setSprite(0, 8'd41, 8'd60, 3'b100);
    modelRun(3'b001, 1, 1'b0);
    req = 3'b001;
    applyStimulus(1, 1'b1, 0, 0, 1'b0);
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t2_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t2_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
    got = ackCycQ.size() > 0 ? ackCycQ[0] : -1;
    checks++;
    if (got != 2*S*S + 1) begin errors++; $display("[TB] FAIL t2_ack_latency: got %0d expected %0d", got, 2*S*S + 1); end
  endtask

  task automatic test_round_robin();
    @(negedge clock);
    applyReset();
    clearQueues();
    for (int i = 0; i < N; i++) setSprite(i, 8'($urandom), 8'($urandom), 3'($urandom));
    modelRun(3'b111, 4, 1'b1);
    req = 3'b111;
    applyStimulus(4, 1'b0, 0, 0, 1'b0);
    checks++;
    if (ackIdxQ.size() != expAckQ.size()) begin
      errors++; $display("[TB] FAIL t3_ack_count: got %0d expected %0d", ackIdxQ.size(), expAckQ.size());
    end
    foreach (expAckQ[k]) if (k < ackIdxQ.size()) begin
      checks++;
      if (ackIdxQ[k] != expAckQ[k]) begin
        errors++; $display("[TB] FAIL t3_ack_order[%0d]: got %0d expected %0d", k, ackIdxQ[k], expAckQ[k]);
      end
    end
    checks++;
    if (busyLowBetween != 3) begin
      errors++; $display("[TB] FAIL t3_idle_gap: got %0d idle cycles expected 3", busyLowBetween);
    end
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t3_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t3_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    int drawStart, expLat, got;
    @(negedge clock);
    clearQueues();
    drawStart = mValid[1] ? S*S + 1 : 1;
    expLat    = (mValid[1] ? 2*S*S : S*S) + 1 + 5;
    setSprite(1, 8'($urandom), 8'($urandom), 3'($urandom));
    modelRun(3'b010, 1, 1'b0);
    req = 3'b010;
    applyStimulus(1, 1'b1, drawStart + 3, 5, 1'b0);
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t4_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t4_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
    got = ackCycQ.size() > 0 ? ackCycQ[0] : -1;
    checks++;
    if (got != expLat) begin errors++; $display("[TB] FAIL t4_ack_latency: got %0d expected %0d", got, expLat); end
  endtask

  task automatic test_reset_mid_erase();
    int got;
    @(negedge clock);
    clearQueues();
    setSprite(2, 8'($urandom), 8'($urandom), 3'b111);
    req = 3'b100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (vga_plot !== 1'b1 || vga_colour !== BG) begin
        errors++; $display("[TB] FAIL t5_erase[%0d]: got plot=%b colour=%b expected 1/%b", c, vga_plot, vga_colour, BG);
      end
    end
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (ack !== '0 || busy !== 1'b0 || vga_plot !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_rst_ctrl: got ack=%b busy=%b plot=%b expected 000/0/0", ack, busy, vga_plot);
    end
    if (vga_x !== 8'd0 || vga_y !== 8'd0) begin
      errors++; $display("[TB] FAIL t5_rst_xy: got %0d,%0d expected 0,0", vga_x, vga_y);
    end
    if (vga_colour !== BG) begin
      errors++; $display("[TB] FAIL t5_rst_colour: got %b expected %b", vga_colour, BG);
    end
    @(negedge clock);
    checks++;
    if (ack !== '0) begin errors++; $display("[TB] FAIL t5_no_ack: got %b expected 000", ack); end
    req     = '0;
    reset_n = 1'b1;
    modelReset();
    @(negedge clock);
    setSprite(2, 8'($urandom), 8'($urandom), 3'($urandom));
    modelRun(3'b100, 1, 1'b0);
    req = 3'b100;
    applyStimulus(1, 1'b1, 0, 0, 1'b0);
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t5_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t5_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
    got = ackCycQ.size() > 0 ? ackCycQ[0] : -1;
    checks++;
    if (got != S*S + 1) begin errors++; $display("[TB] FAIL t5_ack_latency: got %0d expected %0d", got, S*S + 1); end
  endtask

  task automatic test_offscreen_wrap();
    @(negedge clock);
    clearQueues();
    setSprite(1, 8'd158, 8'd118, 3'($urandom_range(1, 7)));
    modelRun(3'b010, 1, 1'b0);
    req = 3'b010;
    applyStimulus(1, 1'b1, 0, 0, 1'b0);
    checks++;
    if (plotQ.size() != expPlotQ.size()) begin
      errors++; $display("[TB] FAIL t6_plot_count: got %0d expected %0d", plotQ.size(), expPlotQ.size());
    end
    foreach (expPlotQ[k]) if (k < plotQ.size()) begin
      checks++;
      if (plotQ[k] !== expPlotQ[k]) begin
        errors++; $display("[TB] FAIL t6_plot[%0d]: got %h expected %h", k, plotQ[k], expPlotQ[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int n;
    for (int r = 0; r < 8; r++) begin
      @(negedge clock);
      clearQueues();
      mask = 3'($urandom_range(1, 7));
      n    = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          setSprite(i, 8'($urandom), 8'($urandom), 3'($urandom));
          n++;
        end
      end
      modelRun(mask, n, 1'b0);
      req = mask;
      applyStimulus(n, 1'b1, $urandom_range(1, 40), $urandom_range(0, 4), 1'b0);
      checks++;
      if (ackIdxQ.size() != expAckQ.size()) begin
        errors++; $display("[TB] FAIL rnd%0d_ack_count: got %0d expected %0d", r, ackIdxQ.size(), expAckQ.size());
      end
      foreach (expAckQ[k]) if (k < ackIdxQ.size()) begin
        checks++;
        if (ackIdxQ[k] != expAckQ[k]) begin
          errors++; $display("[TB] FAIL rnd%0d_ack[%0d]: got %0d expected %0d", r, k, ackIdxQ[k], expAckQ[k]);
        end
      end
      checks++;
      if (plotQ.size() != expPlotQ.size()) begin
        errors++; $display("[TB] FAIL rnd%0d_plot_count: got %0d expected %0d", r, plotQ.size(), expPlotQ.size());
      end
      foreach (expPlotQ[k]) if (k < plotQ.size()) begin
        checks++;
        if (plotQ[k] !== expPlotQ[k]) begin
          errors++; $display("[TB] FAIL rnd%0d_plot[%0d]: got %h expected %h", r, k, plotQ[k], expPlotQ[k]);
        end
      end
    end
  endtask

  // Scenario sequence; each scenario leaves the scheduler idle with no
  // requests pending.
  initial begin
    test_reset();
    test_first_draw();
    test_redraw();
    test_round_robin();
    test_enable_freeze();
    test_reset_mid_erase();
    test_offscreen_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
